instr_fetch_unit: RTL and testbench

//  Fetch front end of KGP-RISC; it supplies the decode stage.
//  - Holds the PC and issues word reads to instruction memory over a req/ack handshake.
//  - Buffers returned words in a 2-entry prefetch FIFO.
//  - Presents opCode/functCode fields to control_unit.
//  - Accepts branch redirects computed from control_unit's CondBr/RegBr/UncondBr outputs.

---
 rtl/kgp_risc_pkg.sv | 14 +
 rtl/prefetch_fifo.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 84 ++++++++
 tb/tb_instr_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_risc_pkg.sv
// kgp_risc_pkg: shared KGP-RISC types, instruction field positions and helpers
package kgp_risc_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} ifu_state_t;
  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int FUNCT_MSB = 7;
  localparam int FUNCT_LSB = 0;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO with flush, holding {instr, pc} prefetch entries
module prefetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] rd, wr;
  logic do_pop, do_push;
  assign count = wr - rd;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd <= wr;
    end else begin
      if (do_push) begin
        mem[wr[AW-1:0]] <= din;
        wr <= wr + 1'b1;
      end
      if (do_pop) rd <= rd + 1'b1;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: KGP-RISC fetch front end; define IFU_PERF_EN to add perf_fetched/perf_flushed counters
module instr_fetch_unit
  import kgp_risc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [5:0]        opCode,
  output logic [7:0]        functCode
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  ifu_state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, tgt;
  logic pop, accept, drop, full, empty, room_idle, room_push;
  logic [CW-1:0] count;
  logic [INSTR_W+ADDR_W-1:0] head;
  prefetch_fifo #(.DEPTH(FIFO_DEPTH), .W(INSTR_W + ADDR_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(redirect), .push(accept), .pop(pop),
    .din({imem_rdata, pc}), .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign instr_valid = ~empty;
  assign pop = instr_valid & instr_ready;
  assign instr = head[INSTR_W+ADDR_W-1:ADDR_W];
  assign instr_pc = head[ADDR_W-1:0];
  assign opCode = instr[OPC_MSB:OPC_LSB];
  assign functCode = instr[FUNCT_MSB:FUNCT_LSB];
  assign tgt = redirect_pc & ~ADDR_W'(3);
  assign accept = state == REQ && imem_ack && !redirect;
  assign drop = imem_ack && (state == DRAIN || (state == REQ && redirect));
  // A slot freed by this cycle's pop counts toward the next request
  assign room_idle = ~full | pop;
  assign room_push = pop ? ~full : count < CW'(FIFO_DEPTH - 1);
  always_comb begin
    pc_n = redirect ? tgt : accept ? pc + ADDR_W'(4) : pc;
    if (redirect) state_n = (state == IDLE) ? (halt ? IDLE : REQ) : (imem_ack ? IDLE : DRAIN);
    else if (state == IDLE) state_n = (!halt && room_idle) ? REQ : IDLE;
    else if (imem_ack) state_n = (state == REQ && !halt && room_push) ? REQ : IDLE;
    else state_n = state;
  end
  // imem_addr only moves when a new request is issued, so it stays stable through DRAIN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      pc <= RESET_PC;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state <= state_n;
      pc <= pc_n;
      imem_req <= state_n != IDLE;
      if (state_n == REQ && (state != REQ || imem_ack)) imem_addr <= pc_n;
    end
`ifdef IFU_PERF_EN
  logic [CW-1:0] dropped;
  assign dropped = redirect ? count - CW'(pop) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, 32'(accept));
      perf_flushed <= sat_add(perf_flushed, 32'(dropped) + 32'(drop));
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed scenarios plus randomized run against a transaction-level fetch model
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0, imem_ack = 0, redirect = 0, halt = 0, instr_ready = 0;
  logic [31:0] imem_rdata = 0, redirect_pc = 0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [5:0] opCode;
  logic [7:0] functCode;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
`endif
  int checks = 0, failures = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .opCode(opCode), .functCode(functCode)
`ifdef IFU_PERF_EN
    , .perf_fetched(perf_fetched), .perf_flushed(perf_flushed)
`endif
  );

  always #5 clk = ~clk;

  // Model: queue of buffered {word, address}, next fetch address, and whether a
  // request is outstanding (and if so whether its data is already doomed).
  typedef struct packed {logic [31:0] w; logic [31:0] a;} ent_t;
  ent_t q[$];
  logic [31:0] m_pc, m_addr, m_fetched, m_flushed;
  bit m_busy, m_doomed;

  function automatic logic [31:0] sat(input logic [31:0] a, input int b);
    longint s;
    s = longint'(a) + longint'(b);
    return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc = 0; m_addr = 0; m_busy = 0; m_doomed = 0; m_fetched = 0; m_flushed = 0;
  endtask

  task automatic model_edge();
    bit pop;
    pop = q.size() > 0 && instr_ready;
    if (redirect) begin
      m_flushed = sat(m_flushed, q.size() - int'(pop) + int'(m_busy && imem_ack));
      q.delete();
      m_pc = redirect_pc & ~32'd3;
      if (m_busy) begin
        if (imem_ack) begin m_busy = 0; m_doomed = 0; end
        else m_doomed = 1;
      end else if (!halt) begin
        m_busy = 1; m_addr = m_pc;
      end
    end else begin
      if (pop) q.delete(0);
      if (m_busy && imem_ack) begin
        if (m_doomed) begin
          m_busy = 0; m_doomed = 0; m_flushed = sat(m_flushed, 1);
        end else begin
          q.push_back('{w: imem_rdata, a: m_pc});
          m_fetched = sat(m_fetched, 1);
          m_pc = m_pc + 4;
          m_busy = !halt && q.size() < DEPTH;
          if (m_busy) m_addr = m_pc;
        end
      end else if (!m_busy && !halt && q.size() < DEPTH) begin
        m_busy = 1; m_addr = m_pc;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    imem_ack = 0; redirect = 0; halt = 0; instr_ready = 0; redirect_pc = 0; imem_rdata = 0;
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if ({imem_req, imem_addr, instr_valid, instr, instr_pc, opCode, functCode} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%b addr=%h v=%b instr=%h pc=%h exp all zero",
               imem_req, imem_addr, instr_valid, instr, instr_pc);
    end
`ifdef IFU_PERF_EN
    checks++;
    if ({perf_fetched, perf_flushed} !== 64'd0) begin
      failures++;
      $display("FAIL reset_perf got %h/%h exp 0/0", perf_fetched, perf_flushed);
    end
`endif
    do_reset();
  endtask

  task automatic test_first_fetch();
    int age = 0, first_valid = -1, n = 0;
    logic [31:0] addrs [3];
    do_reset();
    instr_ready = 1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      step();
      if (instr_valid && first_valid < 0) begin
        first_valid = cyc;
        checks++;
        if (instr !== 32'h2000_0040 || opCode !== 6'h08 || functCode !== 8'h40 || instr_pc !== 0) begin
          failures++;
          $display("FAIL first_word got instr=%h op=%h fn=%h pc=%h exp 20000040/08/40/0",
                   instr, opCode, functCode, instr_pc);
        end
      end
      imem_ack = m_busy && age >= 1;
      if (imem_ack && n < 3) begin addrs[n] = imem_addr; n++; end
      imem_rdata = (n == 1 && imem_ack) ? 32'h2000_0040 : $urandom;
      age = imem_ack ? 0 : (m_busy ? age + 1 : 0);
    end
    imem_ack = 0;
    checks++;
    if (first_valid != 3) begin
      failures++;
      $display("FAIL first_valid_cycle got %0d exp 3", first_valid);
    end
    checks++;
    if (n != 3 || addrs[0] !== 0 || addrs[1] !== 4 || addrs[2] !== 8) begin
      failures++;
      $display("FAIL addr_seq got n=%0d %h %h %h exp 0 4 8", n, addrs[0], addrs[1], addrs[2]);
    end
  endtask

  task automatic test_fill();
    int acks = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step();
      imem_ack = imem_req;
      imem_rdata = $urandom;
      if (imem_ack) acks++;
    end
    imem_ack = 0;
    step();
    checks++;
    if (acks != 2 || imem_req !== 0 || instr_valid !== 1 || instr_pc !== 0) begin
      failures++;
      $display("FAIL fill got acks=%0d req=%b v=%b pc=%h exp 2/0/1/0", acks, imem_req, instr_valid, instr_pc);
    end
    instr_ready = 1;
    step();
    instr_ready = 0;
    checks++;
    if (imem_req !== 1 || imem_addr !== 8 || instr_pc !== 4) begin
      failures++;
      $display("FAIL refill_req got req=%b addr=%h pc=%h exp 1/8/4", imem_req, imem_addr, instr_pc);
    end
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      imem_ack = imem_req;
      if (imem_ack) acks++;
      step();
    end
    imem_ack = 0;
    checks++;
    if (acks != 1 || imem_req !== 0) begin
      failures++;
      $display("FAIL refill_once got acks=%0d req=%b exp 1/0", acks, imem_req);
    end
  endtask

  task automatic test_redirect_drain();
    int leaks = 0;
    do_reset();
    step();
    imem_ack = 1; imem_rdata = 32'h1111_1111;
    step();
    imem_ack = 0;
    redirect = 1; redirect_pc = 32'h103;
    step();
    redirect = 0;
    checks++;
    if (imem_req !== 1 || imem_addr !== 4 || instr_valid !== 0) begin
      failures++;
      $display("FAIL drain_hold got req=%b addr=%h v=%b exp 1/4/0", imem_req, imem_addr, instr_valid);
    end
    step();
    if (instr_valid) leaks++;
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 0;
    if (instr_valid) leaks++;
    checks++;
    if (imem_req !== 0) begin
      failures++;
      $display("FAIL drain_done got req=%b exp 0", imem_req);
    end
    step();
    if (instr_valid) leaks++;
    checks++;
    if (imem_req !== 1 || imem_addr !== 32'h100 || leaks != 0) begin
      failures++;
      $display("FAIL drain_refetch got req=%b addr=%h leaks=%0d exp 1/100/0", imem_req, imem_addr, leaks);
    end
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    step();
    imem_ack = 0;
    checks++;
    if (instr_valid !== 1 || instr !== 32'h1234_5678 || instr_pc !== 32'h100) begin
      failures++;
      $display("FAIL drain_target got v=%b instr=%h pc=%h exp 1/12345678/100", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_ack_redirect();
    do_reset();
    step();
    imem_ack = 1; redirect = 1; redirect_pc = 32'h200; imem_rdata = 32'hCAFE_F00D;
    step();
    imem_ack = 0; redirect = 0;
    checks++;
    if (imem_req !== 0 || instr_valid !== 0) begin
      failures++;
      $display("FAIL ackredir_drop got req=%b v=%b exp 0/0", imem_req, instr_valid);
    end
`ifdef IFU_PERF_EN
    checks++;
    if (perf_flushed !== 1 || perf_fetched !== 0) begin
      failures++;
      $display("FAIL ackredir_perf got flushed=%0d fetched=%0d exp 1/0", perf_flushed, perf_fetched);
    end
`endif
    step();
    checks++;
    if (imem_req !== 1 || imem_addr !== 32'h200) begin
      failures++;
      $display("FAIL ackredir_next got req=%b addr=%h exp 1/200", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt();
    int reqs = 0;
    do_reset();
    step();
    halt = 1;
    step();
    imem_ack = 1; imem_rdata = 32'h0BAD_C0DE;
    step();
    imem_ack = 0;
    checks++;
    if (instr_valid !== 1 || instr !== 32'h0BAD_C0DE || imem_req !== 0) begin
      failures++;
      $display("FAIL halt_buffer got v=%b instr=%h req=%b exp 1/0badc0de/0", instr_valid, instr, imem_req);
    end
    for (int c = 0; c < 4; c++) begin
      step();
      if (imem_req) reqs++;
    end
    halt = 0;
    step();
    checks++;
    if (reqs != 0 || imem_req !== 1 || imem_addr !== 4) begin
      failures++;
      $display("FAIL halt_resume got reqs=%0d req=%b addr=%h exp 0/1/4", reqs, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    instr_ready = 1;
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    imem_ack = 1; imem_rdata = 32'h5555_AAAA;
    step();
    imem_ack = 0;
    checks++;
    if (instr_pc !== 32'hFFFF_FFFC || imem_req !== 1 || imem_addr !== 0) begin
      failures++;
      $display("FAIL wrap got pc=%h req=%b addr=%h exp fffffffc/1/0", instr_pc, imem_req, imem_addr);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({imem_req, imem_addr, instr_valid, instr, instr_pc, opCode, functCode} !== '0) begin
      failures++;
      $display("FAIL async_reset got req=%b addr=%h v=%b instr=%h pc=%h exp all zero",
               imem_req, imem_addr, instr_valid, instr, instr_pc);
    end
    do_reset();
  endtask

  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) halt = !halt;
      instr_ready = $urandom_range(0, 2) != 0;
      redirect = $urandom_range(0, 15) == 0;
      redirect_pc = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      imem_ack = imem_req && $urandom_range(0, 1) == 1;
      imem_rdata = $urandom;
      step();
      checks++;
      if (imem_req !== m_busy || (m_busy && imem_addr !== m_addr) || instr_valid !== (q.size() > 0)) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL rand_ctl c=%0d got req=%b addr=%h v=%b exp %b/%h/%b",
                   c, imem_req, imem_addr, instr_valid, m_busy, m_addr, q.size() > 0);
      end
      if (q.size() > 0) begin
        checks++;
        if (instr !== q[0].w || instr_pc !== q[0].a || opCode !== 6'(q[0].w >> 26) || functCode !== 8'(q[0].w % 256)) begin
          failures++;
          if (bad++ < 10)
            $display("FAIL rand_head c=%0d got %h@%h exp %h@%h", c, instr, instr_pc, q[0].w, q[0].a);
        end
      end
`ifdef IFU_PERF_EN
      checks++;
      if (perf_fetched !== m_fetched || perf_flushed !== m_flushed) begin
        failures++;
        if (bad++ < 10)
          $display("FAIL rand_perf c=%0d got %0d/%0d exp %0d/%0d", c, perf_fetched, perf_flushed, m_fetched, m_flushed);
      end
`endif
    end
    halt = 0; redirect = 0; imem_ack = 0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_fill();
    test_redirect_drain();
    test_ack_redirect();
    test_halt();
    test_wrap_and_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
